// File: rtl/lcd_bus_responder.sv
// HD44780-style 8-bit LCD bus responder: decodes writes into an 80-byte DDRAM and answers reads.
// Commits on falling E; read data is combinational, readback one cycle; transfers while busy are dropped (overrun).
module lcd_bus_responder #(
  parameter int BUSY_CYCLES  = 20,
  parameter int CLEAR_CYCLES = 160
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       lcd_e,
  input  logic       lcd_rw,
  input  logic       lcd_rs,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic       busy,
  output logic [6:0] ddram_addr,
  output logic       display_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       func_8bit,
  output logic       two_line,
  output logic       entry_inc,
  output logic       cmd_valid,
  output logic [8:0] cmd_byte,
  output logic       overrun,
  output logic       addr_err,
  input  logic [6:0] rd_idx,
  output logic [7:0] rd_char
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_EXEC  = 2'd1;
  localparam logic [1:0] S_CLEAR = 2'd2;

  localparam logic [15:0] BUSY_LOAD  = 16'(BUSY_CYCLES - 1);
  localparam logic [15:0] CLEAR_LOAD = 16'(CLEAR_CYCLES - 1);

  logic [1:0]  state;
  logic [15:0] cnt;
  logic [6:0]  fill_idx;
  logic        e_q;
  logic [7:0]  cap_data;
  logic        cap_rw;
  logic        cap_rs;
  logic [7:0]  mem [80];
  logic        commit;
  logic        wr_data_en;

  // Linear DDRAM order: 0x27 steps to 0x40, 0x67 steps to 0x00, and back.
  function automatic logic [6:0] addr_step(input logic [6:0] a, input logic inc);
    logic [6:0] r;
    if (inc) begin
      case (a)
        7'h27:   r = 7'h40;
        7'h67:   r = 7'h00;
        default: r = a + 7'd1;
      endcase
    end else begin
      case (a)
        7'h40:   r = 7'h27;
        7'h00:   r = 7'h67;
        default: r = a - 7'd1;
      endcase
    end
    return r;
  endfunction

  function automatic logic addr_valid(input logic [6:0] a);
    return (a <= 7'h27) || (a >= 7'h40 && a <= 7'h67);
  endfunction

  function automatic logic [6:0] addr_index(input logic [6:0] a);
    return (a < 7'h40) ? a : a - 7'd24;
  endfunction

  assign busy       = (state != S_IDLE);
  assign commit     = e_q && !lcd_e;
  assign wr_data_en = commit && !busy && !cap_rw && cap_rs;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_CLEAR;
      cnt        <= CLEAR_LOAD;
      fill_idx   <= 7'd0;
      e_q        <= 1'b0;
      cap_data   <= 8'h00;
      cap_rw     <= 1'b0;
      cap_rs     <= 1'b0;
      ddram_addr <= 7'h00;
      display_on <= 1'b0;
      cursor_on  <= 1'b0;
      blink_on   <= 1'b0;
      func_8bit  <= 1'b1;
      two_line   <= 1'b0;
      entry_inc  <= 1'b1;
      cmd_valid  <= 1'b0;
      cmd_byte   <= 9'h000;
      overrun    <= 1'b0;
      addr_err   <= 1'b0;
    end else begin
      e_q       <= lcd_e;
      cmd_valid <= 1'b0;
      overrun   <= 1'b0;
      addr_err  <= 1'b0;
      if (lcd_e) begin
        cap_data <= data;
        cap_rw   <= lcd_rw;
        cap_rs   <= lcd_rs;
      end
      if (state != S_IDLE) begin
        if (cnt == 16'd0) state <= S_IDLE;
        else cnt <= cnt - 16'd1;
      end
      if (state == S_CLEAR && fill_idx < 7'd80) fill_idx <= fill_idx + 7'd1;

      if (commit) begin
        if (busy) begin
          // Status reads are always answered; anything else is lost.
          if (!cap_rw || cap_rs) overrun <= 1'b1;
        end else if (cap_rw) begin
          if (cap_rs) ddram_addr <= addr_step(ddram_addr, entry_inc);
        end else begin
          cmd_valid <= 1'b1;
          cmd_byte  <= {cap_rs, cap_data};
          if (cap_rs) begin
            ddram_addr <= addr_step(ddram_addr, entry_inc);
            state      <= S_EXEC;
            cnt        <= BUSY_LOAD;
          end else begin
            casez (cap_data)
              8'b1???????: begin
                if (addr_valid(cap_data[6:0])) ddram_addr <= cap_data[6:0];
                else addr_err <= 1'b1;
                state <= S_EXEC;
                cnt   <= BUSY_LOAD;
              end
              8'b01??????: begin
                state <= S_EXEC;
                cnt   <= BUSY_LOAD;
              end
              8'b001?????: begin
                func_8bit <= cap_data[4];
                two_line  <= cap_data[3];
                state     <= S_EXEC;
                cnt       <= BUSY_LOAD;
              end
              8'b0001????: begin
                if (!cap_data[3]) ddram_addr <= addr_step(ddram_addr, cap_data[2]);
                state <= S_EXEC;
                cnt   <= BUSY_LOAD;
              end
              8'b00001???: begin
                display_on <= cap_data[2];
                cursor_on  <= cap_data[1];
                blink_on   <= cap_data[0];
                state      <= S_EXEC;
                cnt        <= BUSY_LOAD;
              end
              8'b000001??: begin
                entry_inc <= cap_data[1];
                state     <= S_EXEC;
                cnt       <= BUSY_LOAD;
              end
              8'b0000001?: begin
                ddram_addr <= 7'h00;
                state      <= S_EXEC;
                cnt        <= CLEAR_LOAD;
              end
              8'b00000001: begin
                ddram_addr <= 7'h00;
                entry_inc  <= 1'b1;
                state      <= S_CLEAR;
                cnt        <= CLEAR_LOAD;
                fill_idx   <= 7'd0;
              end
              default: ;
            endcase
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == S_CLEAR && fill_idx < 7'd80) mem[fill_idx] <= 8'h20;
      else if (wr_data_en) mem[addr_index(ddram_addr)] <= cap_data;
    end
    rd_char <= (rd_idx < 7'd80) ? mem[rd_idx] : 8'h20;
  end

  always_comb begin
    data_oe  = !reset && lcd_e && lcd_rw;
    data_out = 8'h00;
    if (data_oe) data_out = lcd_rs ? mem[addr_index(ddram_addr)] : {busy, ddram_addr};
  end

endmodule
